// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared definitions for the instruction-fetch control stage.
//   - FSM state encoding (REQ/WAIT/DROP/HOLD)
//   - default PC and instruction widths
//   - sequential PC increment
package fetch_ctrl_pkg;

    localparam int unsigned DEF_PC_W     = 32;
    localparam int unsigned DEF_INSTR_W  = 32;
    localparam int unsigned FETCH_PC_INC = 4;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-memory request/response bus (req/gnt, then rvalid).
//   master : fetch side   (drives imem_req, imem_addr)
//   slave  : memory side  (drives imem_gnt, imem_rvalid, imem_rdata)
interface fetch_ctrl_if
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned PC_W    = DEF_PC_W,
    parameter int unsigned INSTR_W = DEF_INSTR_W
);

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_out_buf.sv
// fetch_out_buf: one-entry valid/ready register holding a fetched instruction and its PC.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load_i          capture instr_i/pc_i and raise valid
//   flush_i         drop the held entry (wins over load and handshake)
//   instr_i, pc_i   entry to capture
//   ready_i         consumer accepts the entry
//   valid_o         entry valid
//   instr_o, pc_o   held entry
module fetch_out_buf
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned PC_W    = DEF_PC_W,
    parameter int unsigned INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    pc_q;

    // Valid flag: flush beats load beats handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    // Payload is only written on load; stays stable while waiting for ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            pc_q    <= '0;
        end else if (load_i && !flush_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch control stage between the PC register and decode.
// Issues one imem request per PC, buffers the response for decode, advances the PC,
// and handles redirects by overriding the next PC and discarding stale responses.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pc_q                          current PC from the PC register
//   pc_d, pc_we                   next PC and write enable back to the PC register
//   imem                          instruction-memory bus (fetch_ctrl_if.master)
//   redirect_valid, redirect_pc   branch/jump/exception redirect
//   if_valid, if_ready            bundle handshake to decode
//   if_instr, if_pc               fetched instruction and its PC
//   fetch_misalign                only with FETCH_ALIGN_CHECK_EN: bundle is a misaligned-PC marker
// Build option: define FETCH_ALIGN_CHECK_EN to suppress fetches from non word-aligned PCs.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned PC_W    = DEF_PC_W,
    parameter int unsigned INSTR_W = DEF_INSTR_W,
    parameter int unsigned PC_INC  = FETCH_PC_INC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    pc_q,
    output logic [PC_W-1:0]    pc_d,
    output logic               pc_we,
    fetch_ctrl_if.master       imem,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic               fetch_misalign
`endif
);

    fetch_state_e       state_q;
    fetch_state_e       state_d;
    logic               misalign_c;
    logic               buf_load_c;
    logic               buf_flush_c;
    logic [INSTR_W-1:0] buf_instr_c;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign_c = (pc_q[1:0] != 2'b00);
`else
    assign misalign_c = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect takes priority in every state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_REQ: begin
                if (redirect_valid) begin
                    // A granted request is still in flight and must be drained.
                    state_d = (imem.imem_gnt && !misalign_c) ? ST_DROP : ST_REQ;
                end else if (misalign_c) begin
                    state_d = ST_HOLD;
                end else if (imem.imem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    state_d = imem.imem_rvalid ? ST_REQ : ST_DROP;
                end else if (imem.imem_rvalid) begin
                    state_d = ST_HOLD;
                end
            end
            ST_DROP: begin
                if (imem.imem_rvalid) begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redirect_valid || if_ready) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    // Output logic; request and PC write are gated off while in reset.
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_q;
        pc_we          = 1'b0;
        pc_d           = pc_q;
        buf_load_c     = 1'b0;
        buf_flush_c    = 1'b0;
        buf_instr_c    = imem.imem_rdata;
        if (!rst) begin
            unique case (state_q)
                ST_REQ: begin
                    imem.imem_req = !misalign_c;
                    if (misalign_c && !redirect_valid) begin
                        buf_load_c  = 1'b1;
                        buf_instr_c = '0;
                    end
                end
                ST_WAIT: begin
                    if (imem.imem_rvalid && !redirect_valid) begin
                        buf_load_c = 1'b1;
                        pc_we      = 1'b1;
                        pc_d       = pc_q + PC_W'(PC_INC);
                    end
                end
                default: ;
            endcase
            if (redirect_valid) begin
                pc_we       = 1'b1;
                pc_d        = redirect_pc;
                buf_flush_c = 1'b1;
            end
        end
    end

    fetch_out_buf #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_out_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (buf_load_c),
        .flush_i (buf_flush_c),
        .instr_i (buf_instr_c),
        .pc_i    (pc_q),
        .ready_i (if_ready),
        .valid_o (if_valid),
        .instr_o (if_instr),
        .pc_o    (if_pc)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;

    // Set when the held bundle came from a misaligned PC (loaded in REQ).
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (buf_flush_c) begin
            misalign_q <= 1'b0;
        end else if (buf_load_c) begin
            misalign_q <= (state_q == ST_REQ);
        end else if (if_valid && if_ready) begin
            misalign_q <= 1'b0;
        end
    end

    assign fetch_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
// The bench models the PC register itself (reset to 0, written on pc_we) and drives
// the imem bus and decode handshake cycle by cycle. Inputs change on the falling edge;
// outputs are checked 1ns later.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc_reg;
    logic [31:0] pc_d;
    logic        pc_we;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    int n_checks;
    int n_fail;

    fetch_ctrl_if #(.PC_W(32), .INSTR_W(32)) imem_if ();

    fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .pc_q           (pc_reg),
        .pc_d           (pc_d),
        .pc_we          (pc_we),
        .imem           (imem_if),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register model fed by the DUT.
    always_ff @(posedge clk) begin
        if (rst) pc_reg <= '0;
        else if (pc_we) pc_reg <= pc_d;
    end

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_1234;
        imem_if.imem_gnt = 1'b0; imem_if.imem_rvalid = 1'b0; imem_if.imem_rdata = '0; if_ready = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        n_checks++; if (imem_if.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b want=0", imem_if.imem_req); end
        n_checks++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL rst_pc_we got=%b want=0", pc_we); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_if_valid got=%b want=0", if_valid); end
        n_checks++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL rst_if_instr got=%h want=0", if_instr); end
        n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_if_pc got=%h want=0", if_pc); end
        @(negedge clk); rst = 1'b0; redirect_valid = 1'b0; #1;
        n_checks++; if (pc_reg !== 32'h0) begin n_fail++; $display("FAIL rst_pc got=%h want=0", pc_reg); end
        n_checks++; if (imem_if.imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_exit_req got=%b want=1", imem_if.imem_req); end
    endtask

    task automatic test_basic_fetch();
        imem_if.imem_gnt = 1'b1; #1;
        n_checks++; if (imem_if.imem_req !== 1'b1) begin n_fail++; $display("FAIL bf_req got=%b want=1", imem_if.imem_req); end
        n_checks++; if (imem_if.imem_addr !== 32'h0) begin n_fail++; $display("FAIL bf_addr got=%h want=0", imem_if.imem_addr); end
        n_checks++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL bf_req_pc_we got=%b want=0", pc_we); end
        @(negedge clk); imem_if.imem_gnt = 1'b0; imem_if.imem_rvalid = 1'b1; imem_if.imem_rdata = 32'h2008000A; #1;
        n_checks++; if (imem_if.imem_req !== 1'b0) begin n_fail++; $display("FAIL bf_wait_req got=%b want=0", imem_if.imem_req); end
        n_checks++; if (pc_we !== 1'b1) begin n_fail++; $display("FAIL bf_pc_we got=%b want=1", pc_we); end
        n_checks++; if (pc_d !== 32'h4) begin n_fail++; $display("FAIL bf_pc_d got=%h want=4", pc_d); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL bf_early_valid got=%b want=0", if_valid); end
        @(negedge clk); imem_if.imem_rvalid = 1'b0; imem_if.imem_rdata = '0; #1;
        n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL bf_if_valid got=%b want=1", if_valid); end
        n_checks++; if (if_instr !== 32'h2008000A) begin n_fail++; $display("FAIL bf_if_instr got=%h want=2008000a", if_instr); end
        n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL bf_if_pc got=%h want=0", if_pc); end
        n_checks++; if (pc_reg !== 32'h4) begin n_fail++; $display("FAIL bf_pc_reg got=%h want=4", pc_reg); end
    endtask

    task automatic test_hold_stall();
        for (int i = 0; i < 5; i++) begin
            if_ready = 1'b0;
            @(negedge clk); #1;
            n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d] got=%b want=1", i, if_valid); end
            n_checks++; if (if_instr !== 32'h2008000A) begin n_fail++; $display("FAIL hold_instr[%0d] got=%h want=2008000a", i, if_instr); end
            n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL hold_pc[%0d] got=%h want=0", i, if_pc); end
            n_checks++; if (imem_if.imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req[%0d] got=%b want=0", i, imem_if.imem_req); end
            n_checks++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL hold_pc_we[%0d] got=%b want=0", i, pc_we); end
        end
        if_ready = 1'b1;
        @(negedge clk); if_ready = 1'b0; #1;
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL hs_valid got=%b want=0", if_valid); end
        n_checks++; if (imem_if.imem_req !== 1'b1) begin n_fail++; $display("FAIL hs_req got=%b want=1", imem_if.imem_req); end
        n_checks++; if (imem_if.imem_addr !== 32'h4) begin n_fail++; $display("FAIL hs_addr got=%h want=4", imem_if.imem_addr); end
    endtask

    task automatic test_redirect_wait();
        imem_if.imem_gnt = 1'b1;
        @(negedge clk); imem_if.imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0040_0020; #1;
        n_checks++; if (pc_we !== 1'b1) begin n_fail++; $display("FAIL rw_pc_we got=%b want=1", pc_we); end
        n_checks++; if (pc_d !== 32'h0040_0020) begin n_fail++; $display("FAIL rw_pc_d got=%h want=00400020", pc_d); end
        @(negedge clk); redirect_valid = 1'b0; #1;
        n_checks++; if (imem_if.imem_req !== 1'b0) begin n_fail++; $display("FAIL rw_drop_req got=%b want=0", imem_if.imem_req); end
        n_checks++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL rw_drop_pc_we got=%b want=0", pc_we); end
        imem_if.imem_rvalid = 1'b1; imem_if.imem_rdata = 32'hDEAD_BEEF; #1;
        n_checks++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL rw_stale_pc_we got=%b want=0", pc_we); end
        @(negedge clk); imem_if.imem_rvalid = 1'b0; #1;
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rw_stale_valid got=%b want=0", if_valid); end
        n_checks++; if (imem_if.imem_req !== 1'b1) begin n_fail++; $display("FAIL rw_req got=%b want=1", imem_if.imem_req); end
        n_checks++; if (imem_if.imem_addr !== 32'h0040_0020) begin n_fail++; $display("FAIL rw_addr got=%h want=00400020", imem_if.imem_addr); end
        imem_if.imem_gnt = 1'b1;
        @(negedge clk); imem_if.imem_gnt = 1'b0; imem_if.imem_rvalid = 1'b1; imem_if.imem_rdata = 32'h1234_5678; #1;
        n_checks++; if (pc_d !== 32'h0040_0024) begin n_fail++; $display("FAIL rw_seq_pc_d got=%h want=00400024", pc_d); end
        @(negedge clk); imem_if.imem_rvalid = 1'b0; #1;
        n_checks++; if (if_instr !== 32'h1234_5678) begin n_fail++; $display("FAIL rw_instr got=%h want=12345678", if_instr); end
        n_checks++; if (if_pc !== 32'h0040_0020) begin n_fail++; $display("FAIL rw_if_pc got=%h want=00400020", if_pc); end
        if_ready = 1'b1;
        @(negedge clk); if_ready = 1'b0; #1;
    endtask

    task automatic test_redirect_rvalid();
        imem_if.imem_gnt = 1'b1;
        @(negedge clk); imem_if.imem_gnt = 1'b0; imem_if.imem_rvalid = 1'b1; imem_if.imem_rdata = 32'hAAAA_5555;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1000; #1;
        n_checks++; if (pc_we !== 1'b1) begin n_fail++; $display("FAIL rr_pc_we got=%b want=1", pc_we); end
        n_checks++; if (pc_d !== 32'h0000_1000) begin n_fail++; $display("FAIL rr_pc_d got=%h want=00001000", pc_d); end
        @(negedge clk); imem_if.imem_rvalid = 1'b0; redirect_valid = 1'b0; #1;
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rr_valid got=%b want=0", if_valid); end
        n_checks++; if (imem_if.imem_req !== 1'b1) begin n_fail++; $display("FAIL rr_req got=%b want=1", imem_if.imem_req); end
        n_checks++; if (imem_if.imem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL rr_addr got=%h want=00001000", imem_if.imem_addr); end
    endtask

    task automatic test_redirect_hold_and_req();
        imem_if.imem_gnt = 1'b1;
        @(negedge clk); imem_if.imem_gnt = 1'b0; imem_if.imem_rvalid = 1'b1; imem_if.imem_rdata = 32'h0BAD_F00D;
        @(negedge clk); imem_if.imem_rvalid = 1'b0; #1;
        n_checks++; if (if_instr !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rh_instr got=%h want=0badf00d", if_instr); end
        if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_2000; #1;
        n_checks++; if (pc_d !== 32'h0000_2000) begin n_fail++; $display("FAIL rh_pc_d got=%h want=00002000", pc_d); end
        @(negedge clk); if_ready = 1'b0; redirect_valid = 1'b0; #1;
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rh_valid got=%b want=0", if_valid); end
        n_checks++; if (imem_if.imem_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL rh_addr got=%h want=00002000", imem_if.imem_addr); end
        // Redirect coincident with grant: the granted response must be drained.
        imem_if.imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_3000; #1;
        n_checks++; if (imem_if.imem_req !== 1'b1) begin n_fail++; $display("FAIL rg_req got=%b want=1", imem_if.imem_req); end
        n_checks++; if (pc_d !== 32'h0000_3000) begin n_fail++; $display("FAIL rg_pc_d got=%h want=00003000", pc_d); end
        @(negedge clk); imem_if.imem_gnt = 1'b0; redirect_valid = 1'b0; #1;
        n_checks++; if (imem_if.imem_req !== 1'b0) begin n_fail++; $display("FAIL rg_drop_req got=%b want=0", imem_if.imem_req); end
        imem_if.imem_rvalid = 1'b1; imem_if.imem_rdata = 32'h1111_1111;
        @(negedge clk); imem_if.imem_rvalid = 1'b0; #1;
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rg_valid got=%b want=0", if_valid); end
        n_checks++; if (imem_if.imem_req !== 1'b1) begin n_fail++; $display("FAIL rg_req2 got=%b want=1", imem_if.imem_req); end
        n_checks++; if (imem_if.imem_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL rg_addr got=%h want=00003000", imem_if.imem_addr); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk); redirect_valid = 1'b0; #1;
        n_checks++; if (imem_if.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_addr got=%h want=fffffffc", imem_if.imem_addr); end
        imem_if.imem_gnt = 1'b1;
        @(negedge clk); imem_if.imem_gnt = 1'b0; imem_if.imem_rvalid = 1'b1; imem_if.imem_rdata = 32'hCAFE_F00D; #1;
        n_checks++; if (pc_we !== 1'b1) begin n_fail++; $display("FAIL wr_pc_we got=%b want=1", pc_we); end
        n_checks++; if (pc_d !== 32'h0) begin n_fail++; $display("FAIL wr_pc_d got=%h want=0", pc_d); end
        @(negedge clk); imem_if.imem_rvalid = 1'b0; #1;
        n_checks++; if (if_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_if_pc got=%h want=fffffffc", if_pc); end
        n_checks++; if (pc_reg !== 32'h0) begin n_fail++; $display("FAIL wr_pc_reg got=%h want=0", pc_reg); end
        if_ready = 1'b1;
        @(negedge clk); if_ready = 1'b0; #1;
    endtask

`ifdef FETCH_ALIGN_CHECK_EN
    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0002;
        @(negedge clk); redirect_valid = 1'b0; #1;
        n_checks++; if (imem_if.imem_req !== 1'b0) begin n_fail++; $display("FAIL ma_req got=%b want=0", imem_if.imem_req); end
        n_checks++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL ma_pc_we got=%b want=0", pc_we); end
        @(negedge clk); #1;
        n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL ma_valid got=%b want=1", if_valid); end
        n_checks++; if (fetch_misalign !== 1'b1) begin n_fail++; $display("FAIL ma_flag got=%b want=1", fetch_misalign); end
        n_checks++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL ma_instr got=%h want=0", if_instr); end
        n_checks++; if (if_pc !== 32'h2) begin n_fail++; $display("FAIL ma_if_pc got=%h want=2", if_pc); end
        n_checks++; if (pc_reg !== 32'h2) begin n_fail++; $display("FAIL ma_pc_reg got=%h want=2", pc_reg); end
        if_ready = 1'b1;
        @(negedge clk); if_ready = 1'b0; #1;
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL ma_hs_valid got=%b want=0", if_valid); end
        n_checks++; if (fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL ma_hs_flag got=%b want=0", fetch_misalign); end
        n_checks++; if (imem_if.imem_req !== 1'b0) begin n_fail++; $display("FAIL ma_hs_req got=%b want=0", imem_if.imem_req); end
    endtask
`endif

    task automatic test_reset_midflight();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0008;
        @(negedge clk); redirect_valid = 1'b0; imem_if.imem_gnt = 1'b1; #1;
        n_checks++; if (imem_if.imem_addr !== 32'h8) begin n_fail++; $display("FAIL rm_addr got=%h want=8", imem_if.imem_addr); end
        @(negedge clk); imem_if.imem_gnt = 1'b0; rst = 1'b1; imem_if.imem_rvalid = 1'b1; imem_if.imem_rdata = 32'h7777_7777; #1;
        n_checks++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL rm_pc_we got=%b want=0", pc_we); end
        n_checks++; if (imem_if.imem_req !== 1'b0) begin n_fail++; $display("FAIL rm_req got=%b want=0", imem_if.imem_req); end
        @(negedge clk); rst = 1'b0; imem_if.imem_rvalid = 1'b0; #1;
        n_checks++; if (pc_reg !== 32'h0) begin n_fail++; $display("FAIL rm_pc_reg got=%h want=0", pc_reg); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid got=%b want=0", if_valid); end
        n_checks++; if (imem_if.imem_req !== 1'b1) begin n_fail++; $display("FAIL rm_req2 got=%b want=1", imem_if.imem_req); end
        n_checks++; if (imem_if.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_addr2 got=%h want=0", imem_if.imem_addr); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_fetch();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_redirect_hold_and_req();
        test_wrap();
`ifdef FETCH_ALIGN_CHECK_EN
        test_misalign();
`endif
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
